// File: rtl/fwd_operand_unit.sv
// Operand forwarding unit: tracks in-flight destinations over STAGES stages, picks the youngest ready producer
// per source operand and raises a load-use stall. Optional stall counter built when FWD_PERF_EN is defined.
module fwd_operand_unit #(
  parameter int DATA_W           = 32,
  parameter int REG_AW           = 5,
  parameter int STAGES           = 3,
  parameter int NOPS             = 2,
  parameter int LOAD_READY_STAGE = 1,
  localparam int SELW            = $clog2(STAGES + 1)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     stall_ext,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic                     id_wen,
  input  logic [REG_AW-1:0]        id_wsel,
  input  logic                     id_is_load,
  input  logic [NOPS*REG_AW-1:0]   id_rsel,
  input  logic [NOPS*DATA_W-1:0]   id_rdat,
  input  logic [STAGES*DATA_W-1:0] stage_result,
  input  logic                     cnt_clr,
  output logic [NOPS*DATA_W-1:0]   op_out,
  output logic [NOPS*SELW-1:0]     fwd_sel,
  output logic                     hazard_stall,
  output logic [15:0]              stall_count
);

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] wen_q, wen_d;
  logic [STAGES-1:0] ld_q, ld_d;
  logic [REG_AW-1:0] wsel_q [STAGES];
  logic [REG_AW-1:0] wsel_d [STAGES];
  logic [NOPS-1:0]   unres;
  logic              hit;

  // Stage 0 is the youngest entry; a stalled or flushed ID slot enters as a bubble.
  always_comb begin
    vld_d  = vld_q;
    wen_d  = wen_q;
    ld_d   = ld_q;
    wsel_d = wsel_q;
    if (!stall_ext) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        vld_d[k]  = vld_q[k-1];
        wen_d[k]  = wen_q[k-1];
        ld_d[k]   = ld_q[k-1];
        wsel_d[k] = wsel_q[k-1];
      end
      vld_d[0]  = id_valid && !hazard_stall && !flush;
      wen_d[0]  = id_wen;
      ld_d[0]   = id_is_load;
      wsel_d[0] = id_wsel;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_q <= '0;
      wen_q <= '0;
      ld_q  <= '0;
      for (int k = 0; k < STAGES; k++) wsel_q[k] <= '0;
    end else begin
      vld_q  <= vld_d;
      wen_q  <= wen_d;
      ld_q   <= ld_d;
      wsel_q <= wsel_d;
    end
  end

  // Only the youngest match is considered; an unready youngest load blocks older stages.
  always_comb begin
    op_out  = id_rdat;
    fwd_sel = '0;
    unres   = '0;
    hit     = 1'b0;
    for (int i = 0; i < NOPS; i++) begin
      hit = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        if (!hit && vld_q[k] && wen_q[k] &&
            (wsel_q[k] == id_rsel[i*REG_AW +: REG_AW]) &&
            (id_rsel[i*REG_AW +: REG_AW] != '0)) begin
          hit = 1'b1;
          if (ld_q[k] && (k < LOAD_READY_STAGE)) begin
            unres[i] = 1'b1;
          end else begin
            fwd_sel[i*SELW +: SELW]  = SELW'(k + 1);
            op_out[i*DATA_W +: DATA_W] = stage_result[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign hazard_stall = id_valid && (|unres);

`ifdef FWD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (hazard_stall && !stall_ext && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign stall_count    = '0;
`endif

endmodule

// File: tb/tb_fwd_operand_unit.sv
// Scoreboard bench for fwd_operand_unit: directed vectors push expectations, a negedge monitor pops and compares.
module tb_fwd_operand_unit;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int STAGES = 3;
  localparam int NOPS   = 2;
  localparam int SELW   = 2;
`ifdef FWD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] R0 = 32'h0000_1000;
  localparam logic [31:0] R1 = 32'h0000_2000;

  logic                     CLK, nRST, stall_ext, flush, id_valid, id_wen, id_is_load, cnt_clr;
  logic [REG_AW-1:0]        id_wsel;
  logic [NOPS*REG_AW-1:0]   id_rsel;
  logic [NOPS*DATA_W-1:0]   id_rdat;
  logic [STAGES*DATA_W-1:0] stage_result;
  logic [NOPS*DATA_W-1:0]   op_out;
  logic [NOPS*SELW-1:0]     fwd_sel;
  logic                     hazard_stall;
  logic [15:0]              stall_count;

  fwd_operand_unit dut (
    .CLK(CLK), .nRST(nRST), .stall_ext(stall_ext), .flush(flush),
    .id_valid(id_valid), .id_wen(id_wen), .id_wsel(id_wsel), .id_is_load(id_is_load),
    .id_rsel(id_rsel), .id_rdat(id_rdat), .stage_result(stage_result), .cnt_clr(cnt_clr),
    .op_out(op_out), .fwd_sel(fwd_sel), .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  typedef struct {
    string       name;
    bit          c0;
    logic [1:0]  fs0;
    logic [31:0] op0;
    bit          c1;
    logic [1:0]  fs1;
    logic [31:0] op1;
    logic        haz;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   sample   = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", n, f, act, expv);
    end
  endtask

  always @(negedge CLK) begin
    if (sample) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL scoreboard: sample requested with empty queue");
      end else begin
        e = exp_q.pop_front();
        cmp(e.name, "hazard_stall", {31'd0, hazard_stall}, {31'd0, e.haz});
        cmp(e.name, "stall_count", {16'd0, stall_count}, {16'd0, e.cnt});
        if (e.c0) begin
          cmp(e.name, "fwd_sel0", {30'd0, fwd_sel[1:0]}, {30'd0, e.fs0});
          cmp(e.name, "op_out0", op_out[31:0], e.op0);
        end
        if (e.c1) begin
          cmp(e.name, "fwd_sel1", {30'd0, fwd_sel[3:2]}, {30'd0, e.fs1});
          cmp(e.name, "op_out1", op_out[63:32], e.op1);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    sample = 1'b0;
  endtask

  task automatic id_set(input bit v, input bit w, input logic [4:0] ws, input bit ld,
                        input logic [4:0] r0, input logic [4:0] r1);
    id_valid   = v;
    id_wen     = w;
    id_wsel    = ws;
    id_is_load = ld;
    id_rsel    = {r1, r0};
  endtask

  task automatic set_res(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    stage_result = {s2, s1, s0};
  endtask

  task automatic chk(input string n, input bit c0, input logic [1:0] f0, input logic [31:0] o0,
                     input bit c1, input logic [1:0] f1, input logic [31:0] o1,
                     input logic h, input logic [15:0] c);
    exp_t x;
    x.name = n; x.c0 = c0; x.fs0 = f0; x.op0 = o0;
    x.c1 = c1; x.fs1 = f1; x.op1 = o1; x.haz = h;
    x.cnt = PERF ? c : 16'h0000;
    exp_q.push_back(x);
    sample = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; stall_ext = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    id_set(0, 0, 0, 0, 8, 9);
    id_rdat = {R1, R0};
    set_res(32'h5000_0000, 32'h5100_0000, 32'h5200_0000);
    step();
    chk("reset", 1, 0, R0, 1, 0, R1, 0, 0);
    step();
    nRST = 1'b1;

    // ALU-to-ALU forward
    id_set(1, 1, 8, 0, 0, 0);
    step();
    id_set(1, 0, 0, 0, 8, 0);
    set_res(32'hDEAD_BEEF, 32'h5100_0000, 32'h5200_0000);
    chk("alu_fwd", 1, 1, 32'hDEAD_BEEF, 1, 0, R1, 0, 0);
    step();

    // Load-use: one stall cycle, then forward from stage 1
    id_set(1, 1, 9, 1, 0, 0);
    step();
    id_set(1, 0, 0, 0, 0, 9);
    chk("load_use_stall", 1, 0, R0, 0, 0, 0, 1, 0);
    step();
    set_res(32'hDEAD_BEEF, 32'h0000_1234, 32'h5200_0000);
    chk("load_use_fwd", 1, 0, R0, 1, 2, 32'h0000_1234, 0, 1);
    step();

    // Youngest producer wins, then ageing through older stages
    id_set(1, 1, 5, 0, 0, 0);
    step();
    id_set(1, 0, 0, 0, 0, 0);
    step();
    id_set(1, 1, 5, 0, 0, 0);
    step();
    id_set(1, 0, 0, 0, 5, 5);
    set_res(32'h0000_AAAA, 32'h0000_CCCC, 32'h0000_BBBB);
    chk("youngest", 1, 1, 32'h0000_AAAA, 1, 1, 32'h0000_AAAA, 0, 1);
    step();
    chk("older_stage", 1, 2, 32'h0000_CCCC, 1, 2, 32'h0000_CCCC, 0, 1);
    step();
    chk("oldest_stage", 1, 3, 32'h0000_BBBB, 1, 3, 32'h0000_BBBB, 0, 1);
    step();
    chk("dropped", 1, 0, R0, 1, 0, R1, 0, 1);
    step();

    // Register 0 load producer: no forward, no stall; r17 from regfile
    id_set(1, 1, 0, 1, 0, 0);
    step();
    id_set(1, 0, 0, 0, 0, 17);
    chk("reg0_regfile", 1, 0, R0, 1, 0, R1, 0, 1);
    step();

    // Freeze holds tracking
    id_set(1, 1, 7, 0, 0, 0);
    step();
    id_set(1, 0, 0, 0, 7, 0);
    stall_ext = 1'b1;
    set_res(32'h7777_0000, 32'h7777_0001, 32'h7777_0002);
    chk("freeze_0", 1, 1, 32'h7777_0000, 1, 0, R1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("freeze_%0d", i + 1), 1, 1, 32'h7777_0000, 1, 0, R1, 0, 1);
    end
    step();
    stall_ext = 1'b0;

    // Flushed write to r6 is never forwarded; r7 has moved to stage 1
    id_set(1, 1, 6, 0, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_set(1, 0, 0, 0, 6, 7);
    chk("flush", 1, 0, R0, 1, 2, 32'h7777_0001, 0, 1);
    step();

    // Asynchronous reset mid-cycle clears forwarding immediately
    nRST = 1'b0;
    chk("async_reset", 1, 0, R0, 1, 0, R1, 0, 0);
    step();
    nRST = 1'b1;
    chk("post_reset", 1, 0, R0, 1, 0, R1, 0, 0);
    step();

    // Counter: three load-use stalls
    set_res(32'h0000_AAAA, 32'h0000_1234, 32'h0000_BBBB);
    for (int i = 0; i < 3; i++) begin
      id_set(1, 1, 9, 1, 0, 0);
      step();
      id_set(1, 0, 0, 0, 0, 9);
      chk($sformatf("cnt_stall_%0d", i), 1, 0, R0, 0, 0, 0, 1, 16'(i));
      step();
      chk($sformatf("cnt_after_%0d", i), 1, 0, R0, 1, 2, 32'h0000_1234, 0, 16'(i + 1));
      step();
    end
    id_set(0, 0, 0, 0, 0, 0);
    chk("cnt_three", 1, 0, R0, 1, 0, R1, 0, 3);
    step();

    // Clear has priority over a simultaneous stall
    id_set(1, 1, 9, 1, 0, 0);
    step();
    id_set(1, 0, 0, 0, 0, 9);
    cnt_clr = 1'b1;
    chk("clr_stall", 1, 0, R0, 0, 0, 0, 1, 3);
    step();
    cnt_clr = 1'b0;
    chk("clr_result", 1, 0, R0, 1, 2, 32'h0000_1234, 0, 0);
    step();

    // Saturation from a preloaded count
`ifdef FWD_PERF_EN
    dut.stall_cnt_q <= 16'hFFFE;
`endif
    id_set(1, 1, 9, 1, 0, 0);
    step();
    id_set(1, 0, 0, 0, 0, 9);
    chk("sat_stall_a", 1, 0, R0, 0, 0, 0, 1, 16'hFFFE);
    step();
    chk("sat_max", 1, 0, R0, 1, 2, 32'h0000_1234, 0, 16'hFFFF);
    step();
    id_set(1, 1, 9, 1, 0, 0);
    step();
    id_set(1, 0, 0, 0, 0, 9);
    chk("sat_stall_b", 1, 0, R0, 0, 0, 0, 1, 16'hFFFF);
    step();
    chk("sat_hold", 1, 0, R0, 1, 2, 32'h0000_1234, 0, 16'hFFFF);
    step();

    id_set(0, 0, 0, 0, 0, 0);
    step();
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fwd_operand_unit.md
Name: fwd_operand_unit

Overview:
- Parametrised successor to the single-operand ALU forwarding mux.
- Tracks destination registers of in-flight instructions across STAGES pipeline stages and resolves NOPS source operands per cycle.
- Selects the youngest ready producer, or the register-file value, for each operand.
- Raises a load-use hazard stall and inserts bubbles itself. Sits between the ID stage and the EX operand inputs of the pipelined datapath.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register-select width
STAGES, 3, tracked in-flight stages (0=EX, 1=MEM, 2=WB)
NOPS, 2, source operands resolved per cycle
LOAD_READY_STAGE, 1, first stage index at which a load's result is valid

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
stall_ext  in  1  external pipeline freeze (memory wait); tracking holds
flush  in  1  squash the instruction currently in ID (enters as bubble)
id_valid  in  1  ID holds a valid instruction
id_wen  in  1  ID instruction writes a register
id_wsel  in  REG_AW  ID destination register
id_is_load  in  1  ID instruction is a load
id_rsel  in  NOPS*REG_AW  source register selects, operand i at [i*REG_AW +: REG_AW]
id_rdat  in  NOPS*DATA_W  register-file read data per operand
stage_result  in  STAGES*DATA_W  result bus of each tracked stage
cnt_clr  in  1  synchronous clear of stall_count
op_out  out  NOPS*DATA_W  resolved operand values
fwd_sel  out  NOPS*SELW  per-operand source: 0=regfile, k+1=stage k; SELW=$clog2(STAGES+1)
hazard_stall  out  1  ID must hold; bubble inserted into stage 0
stall_count  out  16  saturating hazard-stall cycle counter

Behaviour:
- Clock and reset: one clock CLK. Reset nRST is asynchronous, active-low.
- State: STAGES entries {valid, wen, wsel, is_load}. Reset clears all entries to invalid and stall_count to 0.
- Outputs at reset:
  - fwd_sel=0 for all operands.
  - op_out=id_rdat.
  - hazard_stall=0.
- Match, per operand i, combinational:
  - Stage k matches when valid && wen && wsel==rsel_i && rsel_i!=0.
  - Lowest matching k (youngest producer) wins.
  - No match: fwd_sel_i=0, op_out_i=id_rdat_i.
- Readiness: stage k is ready unless is_load && k<LOAD_READY_STAGE.
  - Winner ready: fwd_sel_i=k+1, op_out_i=stage_result[k].
  - Winner not ready: operand is unresolved. No fallback to an older stage.
- hazard_stall = id_valid && (any operand unresolved). Combinational, zero latency.
- Advance: on each rising edge with stall_ext=0:
  - stage[k] <= stage[k-1].
  - stage[0] <= ID entry if id_valid && !hazard_stall && !flush; otherwise a bubble (valid=0).
- stall_ext=1: all entries hold. Outputs keep being recomputed from the held state and current inputs.
- Simultaneous hazard_stall and flush: bubble inserted (same result either way).
- The oldest entry drops off at stage STAGES-1. There is no wrap-around.
- Register 0 is never forwarded and never stalls.
- Reset asserted mid-operation: entries are cleared immediately (asynchronously). Stalls and forwards cease in the same cycle.
- stall_count:
  - Increments on edges where hazard_stall && !stall_ext.
  - Saturates at 16'hFFFF.
  - cnt_clr has priority over increment (result 0).

Optional Feature:
- Macro: FWD_PERF_EN.
- Defined: stall_count and cnt_clr behave as above.
- Undefined: the counter register is not built, stall_count is tied to 0, and cnt_clr is ignored.
- Forwarding and stall behaviour are identical in both builds.

Test Plan:
1. ALU-to-ALU forward:
   - Cycle 0: ID wsel=8, wen=1, non-load. Advance.
   - Cycle 1: rsel0=8, stage_result[0]=0xDEADBEEF.
   - Expect fwd_sel0=1, op_out0=0xDEADBEEF, hazard_stall=0.
2. Load-use:
   - Load to r9 enters stage 0. Next ID rsel1=9.
   - Expect hazard_stall=1 for exactly one cycle, with a bubble inserted.
   - Following cycle: fwd_sel1=2, op_out1=stage_result[1]=0x1234.
3. Youngest wins:
   - r5 written by stage 0 (0xAAAA) and by stage 2 (0xBBBB), both non-load.
   - rsel0=5 -> fwd_sel0=1, op_out0=0xAAAA.
4. Register 0 and regfile path:
   - Producer wsel=0, then rsel0=0 -> fwd_sel0=0, op_out0=id_rdat0, no stall.
   - rsel1=17 with no producer -> op_out1=id_rdat1.
5. Freeze, flush and reset:
   - stall_ext=1 for 3 cycles: tracking holds and forwarding persists unchanged.
   - flush=1 with id_wsel=6: a later rsel=6 is not forwarded.
   - nRST pulsed low mid-sequence: all fwd_sel=0 immediately.
6. Counter (FWD_PERF_EN):
   - 3 load-use stalls -> stall_count=3.
   - cnt_clr together with a stall -> stall_count=0.
   - Preload near saturation and stall -> holds at 0xFFFF.
   - Without the macro: stall_count=0 throughout.
